// File: rtl/qosc_monitor.sv
// Quadrature oscillator monitor: pipelined power check plus quadrant-based
// rotation tracking that locks onto a steady rotation and measures its period.
module qosc_monitor #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_re,
    input  logic [W-1:0]     in_im,
    input  logic [2*W-1:0]   power_lo,
    input  logic [2*W-1:0]   power_hi,
    output logic [2*W-1:0]   power,
    output logic             power_valid,
    output logic             power_ok,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             dir,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, SEARCH, ACQUIRE, LOCKED} state_t;

    // ---------------- power pipeline ----------------
    logic signed [2*W-1:0] re_x, im_x;
    logic [2*W-1:0]        sq_re_d, sq_im_d, power_d;
    logic [2*W-1:0]        sq_re_q, sq_im_q, power_q;
    logic                  v1_q, pow_v_q, pow_ok_q;

    always_comb begin
        re_x    = {{W{in_re[W-1]}}, in_re};
        im_x    = {{W{in_im[W-1]}}, in_im};
        sq_re_d = $unsigned(re_x * re_x);
        sq_im_d = $unsigned(im_x * im_x);
        power_d = sq_re_q + sq_im_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_re_q  <= '0;
            sq_im_q  <= '0;
            v1_q     <= 1'b0;
            power_q  <= '0;
            pow_v_q  <= 1'b0;
            pow_ok_q <= 1'b0;
        end else begin
            v1_q    <= in_valid;
            pow_v_q <= v1_q;
            if (in_valid) begin
                sq_re_q <= sq_re_d;
                sq_im_q <= sq_im_d;
            end
            if (v1_q) begin
                power_q  <= power_d;
                pow_ok_q <= (power_d >= power_lo) && (power_d <= power_hi);
            end
        end
    end

    // ---------------- rotation tracker ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [1:0]       qprev_q, qprev_d, q_in, delta;
    logic             dir_q, dir_d, locked_q, locked_d;
    logic             err_q, err_d, pvalid_q, pvalid_d;
    logic             ccw, cw, skip, bad, rev;

    always_comb begin
        // Q0..Q3 encoded so that a CCW step increments the code mod 4
        q_in  = {in_im[W-1], in_re[W-1] ^ in_im[W-1]};
        delta = q_in - qprev_q;
        ccw   = (delta == 2'd1);
        cw    = (delta == 2'd3);
        skip  = (delta == 2'd2);
        bad   = skip || (dir_q ? cw : ccw);
        rev   = (q_in == 2'd0) && (dir_q ? (qprev_q == 2'd3) : (qprev_q == 2'd1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qprev_d  = qprev_q;
        period_d = period_q;
        dir_d    = dir_q;
        err_d    = 1'b0;
        pvalid_d = 1'b0;
        if (in_valid) begin
            qprev_d = q_in;
            case (state_q)
                IDLE: state_d = SEARCH;
                SEARCH: begin
                    if (skip) begin
                        err_d = 1'b1;
                    end else if (ccw || cw) begin
                        dir_d   = ccw;
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (bad) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = SEARCH;
                    end else if (rev) begin
                        if (state_q == LOCKED) begin
                            period_d = cnt_q + CNT_W'(1);
                            pvalid_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = LOCKED;
                    end else if (state_q == LOCKED) begin
                        // saturated counter is a timeout rather than a wrap
                        if (cnt_q == '1) begin
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = SEARCH;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            qprev_q  <= '0;
            period_q <= '0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qprev_q  <= qprev_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign power        = power_q;
    assign power_valid  = pow_v_q;
    assign power_ok     = pow_ok_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign dir          = dir_q;
    assign locked       = locked_q;
    assign err          = err_q;

endmodule

// File: tb/tb_qosc_monitor.sv
// Directed bench for qosc_monitor: default-width instance plus a CNT_W=4
// instance sharing the same stimulus for the counter timeout.
module tb_qosc_monitor;

    localparam int W = 16;
    localparam logic [W-1:0] POS = 16'h0064;  // +100
    localparam logic [W-1:0] NEG = 16'hFF9C;  // -100

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid;
    logic [W-1:0]   in_re, in_im;
    logic [2*W-1:0] power_lo, power_hi;

    logic [2*W-1:0] power, power4;
    logic           power_valid, power_ok, power_valid4, power_ok4;
    logic [15:0]    period;
    logic [3:0]     period4;
    logic           period_valid, dir, locked, err;
    logic           period_valid4, dir4, locked4, err4;

    qosc_monitor #(.W(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .power_lo(power_lo), .power_hi(power_hi), .power(power),
        .power_valid(power_valid), .power_ok(power_ok), .period(period),
        .period_valid(period_valid), .dir(dir), .locked(locked), .err(err)
    );

    qosc_monitor #(.W(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .power_lo(power_lo), .power_hi(power_hi), .power(power4),
        .power_valid(power_valid4), .power_ok(power_ok4), .period(period4),
        .period_valid(period_valid4), .dir(dir4), .locked(locked4), .err(err4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
        in_valid = v;
        in_re    = re;
        in_im    = im;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_q(input int q);
        case (q)
            0:       drive(1'b1, POS, POS);
            1:       drive(1'b1, NEG, POS);
            2:       drive(1'b1, NEG, NEG);
            default: drive(1'b1, POS, NEG);
        endcase
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_power"},  power, 0);
        check_eq({tag, "_pvalid"}, power_valid, 0);
        check_eq({tag, "_pok"},    power_ok, 0);
        check_eq({tag, "_period"}, period, 0);
        check_eq({tag, "_perv"},   period_valid, 0);
        check_eq({tag, "_dir"},    dir, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_err"},    err, 0);
    endtask

    // 25 samples of the CCW pattern 0,0,1,1,2,2,3,3,...
    task automatic ccw_run(input string tag);
        for (int k = 0; k <= 24; k++) begin
            drive_q((k % 8) / 2);
            if (k == 2)  check_eq({tag, "_dir"}, dir, 1);
            if (k == 7)  check_eq({tag, "_unlocked_k7"}, locked, 0);
            if (k == 8) begin
                check_eq({tag, "_locked_k8"}, locked, 1);
                check_eq({tag, "_perv_k8"}, period_valid, 0);
            end
            if (k == 10) begin
                check_eq({tag, "_pow_k10"}, power, 32'd20000);
                check_eq({tag, "_powv_k10"}, power_valid, 1);
            end
            if (k == 15) check_eq({tag, "_perv_k15"}, period_valid, 0);
            if (k == 16 || k == 24) begin
                check_eq({tag, "_perv_rev"}, period_valid, 1);
                check_eq({tag, "_period_rev"}, period, 8);
                check_eq({tag, "_err_rev"}, err, 0);
            end
            if (k == 17) begin
                check_eq({tag, "_perv_k17"}, period_valid, 0);
                check_eq({tag, "_period_k17"}, period, 8);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
        power_lo = '0; power_hi = '1;
        @(posedge clk); #1;

        // sample offered during reset must be dropped
        in_valid = 1'b1; in_re = 16'h4000; in_im = '0;
        @(posedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;
        drive(1'b0, '0, '0);
        check_eq("rst_sample_dropped", power_valid, 0);

        // single sample power, 2-cycle latency, one-cycle pulse
        drive(1'b1, 16'h4000, 16'h0000);
        check_eq("pow_lat1", power_valid, 0);
        drive(1'b0, '0, '0);
        check_eq("pow_valid", power_valid, 1);
        check_eq("pow_value", power, 32'h1000_0000);
        check_eq("pow_ok", power_ok, 1);
        drive(1'b0, '0, '0);
        check_eq("pow_pulse_end", power_valid, 0);

        // extreme magnitude, back-to-back samples, inclusive upper bound
        power_hi = 32'h7FFF_FFFF;
        drive(1'b1, 16'h8000, 16'h8000);
        drive(1'b1, 16'h8000, 16'h8000);
        check_eq("ext_valid_a", power_valid, 1);
        check_eq("ext_power_a", power, 32'h8000_0000);
        check_eq("ext_ok_a", power_ok, 0);
        power_hi = 32'h8000_0000;
        drive(1'b0, '0, '0);
        check_eq("ext_valid_b", power_valid, 1);
        check_eq("ext_ok_b_incl", power_ok, 1);
        drive(1'b0, '0, '0);
        check_eq("ext_pulse_end", power_valid, 0);

        // CCW lock and period measurement
        power_lo = '0; power_hi = '1;
        do_reset();
        ccw_run("lock");

        // skip while locked: Q0 then Q2
        drive_q(0);
        check_eq("skip_pre_err", err, 0);
        check_eq("skip_pre_locked", locked, 1);
        drive_q(2);
        check_eq("skip_err", err, 1);
        check_eq("skip_locked", locked, 0);
        check_eq("skip_period", period, 8);
        drive_q(3);
        check_eq("skip_err_once", err, 0);
        check_eq("search_to_acq", locked, 0);
        drive_q(0);
        check_eq("relock", locked, 1);
        check_eq("relock_no_perv", period_valid, 0);

        // reset while locked with a sample in stage 1
        drive_q(1);
        check_eq("pre_rst_locked", locked, 1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        rst = 1'b0;
        drive(1'b0, '0, '0);
        check_eq("midrst_no_pvalid", power_valid, 0);
        ccw_run("relock");

        // timeout: hold Q1 after lock; only the 4-bit counter saturates
        for (int i = 1; i <= 16; i++) begin
            drive_q(1);
            if (i == 15) begin
                check_eq("tmo_err_15", err4, 0);
                check_eq("tmo_locked_15", locked4, 1);
            end
            if (i == 16) begin
                check_eq("tmo_err_16", err4, 1);
                check_eq("tmo_locked_16", locked4, 0);
                check_eq("wide_no_tmo_err", err, 0);
                check_eq("wide_still_locked", locked, 1);
            end
        end
        drive(1'b0, '0, '0);
        check_eq("tmo_err_once", err4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
